// File: rtl/vend_sequencer.sv
// Vending-machine purchase controller: accumulates coin credit in nickels,
// sequences select/cancel requests, times the dispense strobe and pays change
// back as discrete nickel pulses. All outputs come straight from registers.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no credit held, waiting for the first accepted coin
// ACCUM  | credit held, waiting for more coins, select or cancel
// VEND   | dispense strobe active, down-counter times its width
// CHANGE | returning remaining credit, one nickel pulse every 2 clocks
module vend_sequencer #(
    parameter int CREDIT_W    = 5,
    parameter int PRICE       = 15,
    parameter int MAX_CREDIT  = 30,
    parameter int VEND_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_n,
    input  logic                coin_d,
    input  logic                coin_q,
    input  logic                sel,
    input  logic                cancel,
    input  logic                stock_ok,
    output logic                dispense,
    output logic                change_n,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          cs,
    output logic                busy
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam int TMR_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

    localparam logic [SUM_W-1:0]    MAX_SUM   = SUM_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [TMR_W-1:0]    VEND_LOAD = TMR_W'(VEND_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0000,
        S_ACCUM  = 4'b0001,
        S_VEND   = 4'b0010,
        S_CHANGE = 4'b0100
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] vend_tmr;

    logic [2:0]       coin_val;
    logic             coin_any;
    logic             coin_multi;
    logic             coin_open;
    logic [SUM_W-1:0] coin_sum;
    logic             coin_ok;
    logic             rej_next;
    logic             can_buy;

    assign cs = state;

    // Coin evaluation: only the highest-value coin is considered; any extra
    // coin in the same cycle is always bounced to the return slot.
    always_comb begin
        coin_val   = 3'd0;
        if (coin_q)      coin_val = 3'd5;
        else if (coin_d) coin_val = 3'd2;
        else if (coin_n) coin_val = 3'd1;
        coin_any   = coin_q | coin_d | coin_n;
        coin_multi = (coin_q & (coin_d | coin_n)) | (coin_d & coin_n);
        coin_open  = (state == S_IDLE) || (state == S_ACCUM);
        coin_sum   = {1'b0, credit} + SUM_W'(coin_val);
        coin_ok    = coin_open && coin_any && (coin_sum <= MAX_SUM);
        rej_next   = (coin_any && !coin_ok) || coin_multi;
        can_buy    = sel && stock_ok && (credit >= PRICE_C);
    end

    // Purchase FSM with registered strobes, credit and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            credit   <= '0;
            dispense <= 1'b0;
            change_n <= 1'b0;
            coin_rej <= 1'b0;
            busy     <= 1'b0;
            vend_tmr <= '0;
        end else begin
            coin_rej <= rej_next;
            change_n <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (coin_ok) begin
                        credit <= coin_sum[CREDIT_W-1:0];
                        state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // An accepted coin defers select/cancel to the next cycle
                    if (coin_ok) begin
                        credit <= coin_sum[CREDIT_W-1:0];
                    end else if (cancel) begin
                        state <= S_CHANGE;
                        busy  <= 1'b1;
                    end else if (can_buy) begin
                        credit   <= credit - PRICE_C;
                        state    <= S_VEND;
                        busy     <= 1'b1;
                        dispense <= 1'b1;
                        vend_tmr <= VEND_LOAD;
                    end
                end
                S_VEND: begin
                    if (vend_tmr == '0) begin
                        dispense <= 1'b0;
                        if (credit != '0) begin
                            state <= S_CHANGE;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        vend_tmr <= vend_tmr - TMR_W'(1);
                    end
                end
                S_CHANGE: begin
                    if (credit == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (!change_n) begin
                        change_n <= 1'b1;
                        credit   <= credit - CREDIT_W'(1);
                        if (credit == CREDIT_W'(1)) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    credit   <= '0;
                    dispense <= 1'b0;
                    busy     <= 1'b0;
                    vend_tmr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: coin results and change pulses are
// predicted by a small credit model and queued, then popped and compared as
// the design produces them.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_n = 1'b0, coin_d = 1'b0, coin_q = 1'b0;
    logic       sel = 1'b0, cancel = 1'b0, stock_ok = 1'b1;
    logic       dispense, change_n, coin_rej, busy;
    logic [4:0] credit;
    logic [3:0] cs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] credit;
        logic       rej;
    } coin_exp_t;

    coin_exp_t  coin_sb[$];
    logic [4:0] pulse_sb[$];

    int m_credit = 0;
    bit m_open   = 1'b1;

    vend_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q),
        .sel(sel), .cancel(cancel), .stock_ok(stock_ok),
        .dispense(dispense), .change_n(change_n), .coin_rej(coin_rej),
        .credit(credit), .cs(cs), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; coin_n = 0; coin_d = 0; coin_q = 0;
        sel = 0; cancel = 0; stock_ok = 1;
        tick; tick;
        rst_n = 1'b1;
        m_credit = 0; m_open = 1'b1;
        coin_sb.delete(); pulse_sb.delete();
    endtask

    // Drive one coin cycle and queue the model's prediction for it.
    task automatic drive_coin(input logic n, input logic d, input logic q);
        int        val;
        bit        acc;
        coin_exp_t e;
        val = q ? 5 : (d ? 2 : (n ? 1 : 0));
        acc = m_open && (val != 0) && (m_credit + val <= 30);
        e.rej = ((val != 0) && !acc) || ((int'(n) + int'(d) + int'(q)) > 1);
        if (acc) m_credit += val;
        e.credit = 5'(m_credit);
        coin_sb.push_back(e);
        coin_n = n; coin_d = d; coin_q = q;
        tick;
        coin_n = 0; coin_d = 0; coin_q = 0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (cs !== 4'b0000 || credit !== 5'd0 || dispense !== 1'b0 ||
            change_n !== 1'b0 || coin_rej !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cs=%b credit=%0d disp=%b chg=%b rej=%b busy=%b, want all 0",
                     cs, credit, dispense, change_n, coin_rej, busy);
        end
        apply_reset;
    endtask

    task automatic test_exact_purchase;
        coin_exp_t e;
        int cnt, pulses;
        apply_reset;
        for (int i = 0; i < 3; i++) begin
            drive_coin(0, 0, 1);
            e = coin_sb.pop_front();
            checks++;
            if (credit !== e.credit || coin_rej !== e.rej || cs !== 4'b0001) begin
                errors++;
                $display("FAIL exact_coin%0d: credit=%0d rej=%b cs=%b, want credit=%0d rej=%b cs=0001",
                         i, credit, coin_rej, cs, e.credit, e.rej);
            end
        end
        sel = 1; tick; sel = 0;
        m_credit -= 15; m_open = 0;
        checks++;
        if (cs !== 4'b0010 || dispense !== 1'b1 || credit !== 5'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL exact_vend_entry: cs=%b disp=%b credit=%0d busy=%b, want 0010 1 0 1",
                     cs, dispense, credit, busy);
        end
        cnt = 0; pulses = 0;
        for (int i = 0; i < 20 && dispense === 1'b1; i++) begin
            cnt++;
            if (change_n) pulses++;
            tick;
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL exact_dispense_len: got %0d cycles, want 4", cnt);
        end
        checks++;
        if (cs !== 4'b0000 || credit !== 5'd0) begin
            errors++;
            $display("FAIL exact_exit: cs=%b credit=%0d, want 0000 0", cs, credit);
        end
        for (int i = 0; i < 10; i++) begin
            if (change_n) pulses++;
            tick;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL exact_no_change: got %0d pulses, want 0", pulses);
        end
    endtask

    task automatic test_overpay;
        coin_exp_t  e;
        logic [4:0] exp_c;
        int cnt, n, last;
        apply_reset;
        for (int i = 0; i < 4; i++) begin
            drive_coin(0, 0, 1);
            e = coin_sb.pop_front();
            checks++;
            if (credit !== e.credit || coin_rej !== e.rej) begin
                errors++;
                $display("FAIL overpay_coin%0d: credit=%0d rej=%b, want %0d %b",
                         i, credit, coin_rej, e.credit, e.rej);
            end
        end
        sel = 1; tick; sel = 0;
        m_credit -= 15; m_open = 0;
        checks++;
        if (cs !== 4'b0010 || credit !== 5'd5) begin
            errors++;
            $display("FAIL overpay_vend: cs=%b credit=%0d, want 0010 5", cs, credit);
        end
        for (int k = m_credit - 1; k >= 0; k--) pulse_sb.push_back(5'(k));
        cnt = 0;
        for (int i = 0; i < 20 && dispense === 1'b1; i++) begin
            cnt++;
            tick;
        end
        checks++;
        if (cnt != 4 || cs !== 4'b0100) begin
            errors++;
            $display("FAIL overpay_to_change: dispense %0d cycles cs=%b, want 4 0100", cnt, cs);
        end
        n = 0; last = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (change_n === 1'b1) begin
                exp_c = pulse_sb.pop_front();
                checks++;
                if (credit !== exp_c) begin
                    errors++;
                    $display("FAIL overpay_pulse%0d_credit: got %0d want %0d", n, credit, exp_c);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL overpay_pulse%0d_spacing: got %0d want 2", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
                if (pulse_sb.size() == 0) break;
            end
            tick;
        end
        checks++;
        if (n != 5 || pulse_sb.size() != 0) begin
            errors++;
            $display("FAIL overpay_pulse_count: got %0d want 5", n);
        end
        tick;
        checks++;
        if (cs !== 4'b0000 || credit !== 5'd0 || change_n !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overpay_exit: cs=%b credit=%0d chg=%b busy=%b, want 0000 0 0 0",
                     cs, credit, change_n, busy);
        end
    endtask

    task automatic test_ceiling_priority;
        coin_exp_t e;
        apply_reset;
        for (int i = 0; i < 5; i++) drive_coin(0, 0, 1);
        drive_coin(0, 1, 0);
        drive_coin(1, 0, 0);
        while (coin_sb.size() > 1) void'(coin_sb.pop_front());
        e = coin_sb.pop_front();
        checks++;
        if (credit !== e.credit) begin
            errors++;
            $display("FAIL ceiling_setup: credit=%0d want %0d", credit, e.credit);
        end
        drive_coin(1, 0, 1);
        e = coin_sb.pop_front();
        checks++;
        if (credit !== e.credit || coin_rej !== e.rej) begin
            errors++;
            $display("FAIL ceiling_q_plus_n: credit=%0d rej=%b, want %0d %b",
                     credit, coin_rej, e.credit, e.rej);
        end
        tick;
        checks++;
        if (coin_rej !== 1'b0) begin
            errors++;
            $display("FAIL ceiling_single_rej: rej=%b one cycle later, want 0", coin_rej);
        end
        drive_coin(1, 1, 0);
        e = coin_sb.pop_front();
        checks++;
        if (credit !== e.credit || coin_rej !== e.rej) begin
            errors++;
            $display("FAIL priority_d_plus_n: credit=%0d rej=%b, want %0d %b",
                     credit, coin_rej, e.credit, e.rej);
        end
        drive_coin(1, 0, 0);
        e = coin_sb.pop_front();
        checks++;
        if (credit !== e.credit || coin_rej !== e.rej) begin
            errors++;
            $display("FAIL ceiling_full_nickel: credit=%0d rej=%b, want %0d %b",
                     credit, coin_rej, e.credit, e.rej);
        end
    endtask

    task automatic test_cancel_vs_select;
        coin_exp_t e;
        int pulses, disp;
        apply_reset;
        for (int i = 0; i < 3; i++) drive_coin(0, 0, 1);
        while (coin_sb.size() > 1) void'(coin_sb.pop_front());
        e = coin_sb.pop_front();
        checks++;
        if (credit !== e.credit) begin
            errors++;
            $display("FAIL cancel_setup: credit=%0d want %0d", credit, e.credit);
        end
        sel = 1; cancel = 1; tick; sel = 0; cancel = 0;
        checks++;
        if (cs !== 4'b0100 || dispense !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_wins: cs=%b disp=%b busy=%b, want 0100 0 1", cs, dispense, busy);
        end
        pulses = 0; disp = 0;
        for (int i = 0; i < 60; i++) begin
            if (dispense) disp++;
            if (change_n) pulses++;
            if (cs === 4'b0000 && change_n === 1'b0) break;
            tick;
        end
        checks++;
        if (pulses != 15 || disp != 0 || credit !== 5'd0 || cs !== 4'b0000) begin
            errors++;
            $display("FAIL cancel_refund: pulses=%0d disp=%0d credit=%0d cs=%b, want 15 0 0 0000",
                     pulses, disp, credit, cs);
        end
    endtask

    task automatic test_insufficient_stock;
        coin_exp_t e;
        apply_reset;
        drive_coin(0, 0, 1);
        drive_coin(0, 0, 1);
        void'(coin_sb.pop_front());
        void'(coin_sb.pop_front());
        sel = 1; tick;
        checks++;
        if (cs !== 4'b0001 || credit !== 5'd10 || dispense !== 1'b0) begin
            errors++;
            $display("FAIL insufficient_sel: cs=%b credit=%0d disp=%b, want 0001 10 0",
                     cs, credit, dispense);
        end
        drive_coin(0, 0, 1);
        e = coin_sb.pop_front();
        checks++;
        if (credit !== e.credit || cs !== 4'b0001) begin
            errors++;
            $display("FAIL coin_with_sel: credit=%0d cs=%b, want %0d 0001", credit, cs, e.credit);
        end
        stock_ok = 0; tick;
        checks++;
        if (cs !== 4'b0001 || credit !== 5'd15) begin
            errors++;
            $display("FAIL no_stock_sel: cs=%b credit=%0d, want 0001 15", cs, credit);
        end
        stock_ok = 1; tick; sel = 0;
        m_credit -= 15; m_open = 0;
        checks++;
        if (cs !== 4'b0010 || credit !== 5'd0 || dispense !== 1'b1) begin
            errors++;
            $display("FAIL stock_back_vend: cs=%b credit=%0d disp=%b, want 0010 0 1",
                     cs, credit, dispense);
        end
        drive_coin(0, 1, 0);
        e = coin_sb.pop_front();
        checks++;
        if (credit !== e.credit || coin_rej !== e.rej || cs !== 4'b0010) begin
            errors++;
            $display("FAIL coin_in_vend: credit=%0d rej=%b cs=%b, want %0d %b 0010",
                     credit, coin_rej, cs, e.credit, e.rej);
        end
        for (int i = 0; i < 10 && cs !== 4'b0000; i++) tick;
        checks++;
        if (cs !== 4'b0000 || credit !== 5'd0) begin
            errors++;
            $display("FAIL vend_return_idle: cs=%b credit=%0d, want 0000 0", cs, credit);
        end
    endtask

    task automatic test_reset_mid_change;
        int pulses;
        apply_reset;
        drive_coin(0, 1, 0);
        drive_coin(1, 0, 0);
        coin_sb.delete();
        cancel = 1; tick; cancel = 0;
        checks++;
        if (cs !== 4'b0100 || credit !== 5'd3) begin
            errors++;
            $display("FAIL midchange_setup: cs=%b credit=%0d, want 0100 3", cs, credit);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cs !== 4'b0000 || credit !== 5'd0 || dispense !== 1'b0 ||
            change_n !== 1'b0 || coin_rej !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midchange_async_reset: cs=%b credit=%0d disp=%b chg=%b rej=%b busy=%b, want all 0",
                     cs, credit, dispense, change_n, coin_rej, busy);
        end
        tick; tick;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (change_n) pulses++;
            tick;
        end
        checks++;
        if (pulses != 0 || cs !== 4'b0000 || credit !== 5'd0) begin
            errors++;
            $display("FAIL midchange_after_release: pulses=%0d cs=%b credit=%0d, want 0 0000 0",
                     pulses, cs, credit);
        end
    endtask

    initial begin
        test_reset;
        test_exact_purchase;
        test_overpay;
        test_ceiling_priority;
        test_cancel_vs_select;
        test_insufficient_stock;
        test_reset_mid_change;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
